// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE configuration master.
// No logic; pure declarations.
// Not applicable: no handshakes live here.
package redmule_pkg;

    // Default number of job registers programmed per job.
    localparam int unsigned REDMULE_REGS = 12;

    // Control-slave register offsets, relative to the accelerator base address.
    localparam logic [31:0] REDMULE_TRIGGER    = 32'h0000_0000;
    localparam logic [31:0] REDMULE_ACQUIRE    = 32'h0000_0004;
    localparam logic [31:0] REDMULE_STATUS     = 32'h0000_000C;
    localparam logic [31:0] REDMULE_SOFT_CLEAR = 32'h0000_0014;
    localparam logic [31:0] REDMULE_REG_BASE   = 32'h0000_0040;

    // Idle cycles between a refused acquire and the next attempt.
    localparam int unsigned REDMULE_BACKOFF_CYCLES = 8;

    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_ACQ_REQ,
        CFG_ACQ_RESP,
        CFG_BACKOFF,
        CFG_PROG,
        CFG_TRIG,
        CFG_WAIT_EVT,
        CFG_DONE
    } cfg_state_e;

    // Offset of job register idx from the base address.
    function automatic logic [31:0] redmule_job_reg_offset(input logic [31:0] idx);
        return REDMULE_REG_BASE + (idx << 2);
    endfunction

endpackage

// File: rtl/redmule_cfg_master_if.sv
// hwpe_ctrl periph bus: request channel plus id-tagged response channel.
// No logic; wiring only.
// Request held until gnt; responses are unconditionally accepted by the master.
interface redmule_cfg_master_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned ID_WIDTH  = 8
);
    logic                 req;
    logic                 gnt;
    logic [AddrWidth-1:0] add;
    logic                 wen;
    logic [3:0]           be;
    logic [31:0]          data;
    logic [ID_WIDTH-1:0]  id;
    logic                 r_valid;
    logic [31:0]          r_data;
    logic [ID_WIDTH-1:0]  r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_valid, r_data, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_valid, r_data, r_id
    );
endinterface

// File: rtl/redmule_periph_txn.sv
// Single-outstanding periph transaction engine with id tagging.
// Request visible the cycle start_i rises; writes finish on gnt, reads on matching r_valid.
// Holds req/add/wen/data/id stable until gnt; ignores start_i while a read is outstanding.
module redmule_periph_txn
    import redmule_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned ID_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] add_i,
    input  logic                 wen_i,
    input  logic [31:0]          data_i,
    output logic                 gnt_o,
    output logic                 txn_done_o,
    output logic [31:0]          rdata_o,
    redmule_cfg_master_if.master periph
);

    logic                 req_q;
    logic                 pend_q;
    logic                 wen_q;
    logic [AddrWidth-1:0] add_q;
    logic [31:0]          data_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic [ID_WIDTH-1:0]  id_cnt_q;
    logic                 issue;
    logic                 rsp_match;

    // A new transaction starts only with nothing in flight; clear kills it immediately.
    assign issue     = start_i & ~req_q & ~pend_q & ~clear_i;
    assign rsp_match = pend_q & periph.r_valid & (periph.r_id == id_q);

    // The issue cycle presents the inputs directly; later stall cycles replay the latched copy.
    assign periph.req  = (req_q & ~clear_i) | issue;
    assign periph.add  = issue ? add_i     : add_q;
    assign periph.wen  = issue ? wen_i     : wen_q;
    assign periph.data = issue ? data_i    : data_q;
    assign periph.id   = issue ? id_cnt_q  : id_q;
    assign periph.be   = 4'hF;

    assign gnt_o      = periph.req & periph.gnt;
    assign txn_done_o = (gnt_o & ~periph.wen) | rsp_match;
    assign rdata_o    = periph.r_data;

    // Latch the request on issue, track grant and the outstanding read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q    <= 1'b0;
            pend_q   <= 1'b0;
            wen_q    <= 1'b1;
            add_q    <= '0;
            data_q   <= '0;
            id_q     <= '0;
            id_cnt_q <= '0;
        end else if (clear_i) begin
            req_q    <= 1'b0;
            pend_q   <= 1'b0;
            wen_q    <= 1'b1;
            add_q    <= '0;
            data_q   <= '0;
            id_q     <= '0;
            id_cnt_q <= '0;
        end else begin
            if (issue) begin
                add_q    <= add_i;
                wen_q    <= wen_i;
                data_q   <= data_i;
                id_q     <= id_cnt_q;
                id_cnt_q <= id_cnt_q + ID_WIDTH'(1);
            end
            if (gnt_o) begin
                req_q  <= 1'b0;
                pend_q <= periph.wen;
            end else if (issue) begin
                req_q <= 1'b1;
            end
            if (rsp_match) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/redmule_cfg_master.sv
// Acquires a RedMulE job context, programs the job registers, triggers and waits for end-of-job.
// One request per cycle at best; acquire refusals back off for a fixed idle window.
// job_ready_o only in IDLE; periph stalls via gnt are absorbed without losing data.
module redmule_cfg_master
    import redmule_pkg::*;
#(
    parameter int unsigned N_REGS    = REDMULE_REGS,
    parameter int unsigned ID_WIDTH  = 8,
    parameter int unsigned AddrWidth = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_RETRY = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [N_REGS-1:0][31:0] job_regs_i,
    redmule_cfg_master_if.master   periph,
    input  logic                   evt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [7:0]             job_id_o
);

    localparam int unsigned IdxW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
    localparam int unsigned BoW    = $clog2(REDMULE_BACKOFF_CYCLES);

    cfg_state_e              state_q, state_d;
    logic [N_REGS-1:0][31:0] job_regs_q;
    logic [IdxW-1:0]         idx_q;
    logic [RetryW-1:0]       retry_q;
    logic [BoW-1:0]          backoff_q;
    logic                    error_q;
    logic [7:0]              job_id_q;
    logic                    evt_q;

    logic                    txn_start;
    logic [AddrWidth-1:0]    txn_add;
    logic                    txn_wen;
    logic [31:0]             txn_data;
    logic                    txn_gnt;
    logic                    txn_done;
    logic [31:0]             txn_rdata;

    logic                    job_accept;
    logic                    acq_ok;
    logic                    acq_fail;
    logic                    retry_last;
    logic                    prog_step;
    logic                    evt_capture;

    // Only the busy flag and the context id carry meaning in an acquire response.
    logic                    unused_rdata_bits;
    assign unused_rdata_bits = ^txn_rdata[30:8];

    assign retry_last = (retry_q == RetryW'(MAX_RETRY - 1));

    redmule_periph_txn #(
        .AddrWidth (AddrWidth),
        .ID_WIDTH  (ID_WIDTH)
    ) i_txn (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (txn_start),
        .add_i      (txn_add),
        .wen_i      (txn_wen),
        .data_i     (txn_data),
        .gnt_o      (txn_gnt),
        .txn_done_o (txn_done),
        .rdata_o    (txn_rdata),
        .periph     (periph)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CFG_IDLE;
        end else if (clear_i) begin
            state_q <= CFG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, transaction request and datapath strobes.
    always_comb begin
        state_d     = state_q;
        txn_start   = 1'b0;
        txn_wen     = 1'b1;
        txn_add     = '0;
        txn_data    = '0;
        job_accept  = 1'b0;
        acq_ok      = 1'b0;
        acq_fail    = 1'b0;
        prog_step   = 1'b0;
        evt_capture = 1'b0;
        case (state_q)
            CFG_IDLE: begin
                if (job_valid_i) begin
                    job_accept = 1'b1;
                    state_d    = CFG_ACQ_REQ;
                end
            end
            CFG_ACQ_REQ: begin
                txn_start = 1'b1;
                txn_wen   = 1'b1;
                txn_add   = AddrWidth'(BASE_ADDR + REDMULE_ACQUIRE);
                if (txn_gnt) begin
                    state_d = CFG_ACQ_RESP;
                end
            end
            CFG_ACQ_RESP: begin
                if (txn_done) begin
                    if (!txn_rdata[31]) begin
                        acq_ok  = 1'b1;
                        state_d = CFG_PROG;
                    end else begin
                        acq_fail = 1'b1;
                        state_d  = retry_last ? CFG_IDLE : CFG_BACKOFF;
                    end
                end
            end
            CFG_BACKOFF: begin
                if (backoff_q == BoW'(REDMULE_BACKOFF_CYCLES - 1)) begin
                    state_d = CFG_ACQ_REQ;
                end
            end
            CFG_PROG: begin
                txn_start = 1'b1;
                txn_wen   = 1'b0;
                txn_add   = AddrWidth'(BASE_ADDR + redmule_job_reg_offset(32'(idx_q)));
                txn_data  = job_regs_q[idx_q];
                if (txn_done) begin
                    prog_step = 1'b1;
                    if (idx_q == IdxW'(N_REGS - 1)) begin
                        state_d = CFG_TRIG;
                    end
                end
            end
            CFG_TRIG: begin
                txn_start = 1'b1;
                txn_wen   = 1'b0;
                txn_add   = AddrWidth'(BASE_ADDR + REDMULE_TRIGGER);
                txn_data  = '0;
                if (txn_done) begin
                    evt_capture = evt_i;
                    state_d     = CFG_WAIT_EVT;
                end
            end
            CFG_WAIT_EVT: begin
                if (evt_i || evt_q) begin
                    state_d = CFG_DONE;
                end
            end
            CFG_DONE: begin
                state_d = CFG_IDLE;
            end
            default: begin
                state_d = CFG_IDLE;
            end
        endcase
    end

    // Job data, register index, retry/backoff counters, sticky error and early-event capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            job_regs_q <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            backoff_q  <= '0;
            error_q    <= 1'b0;
            job_id_q   <= '0;
            evt_q      <= 1'b0;
        end else if (clear_i) begin
            job_regs_q <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            backoff_q  <= '0;
            error_q    <= 1'b0;
            job_id_q   <= '0;
            evt_q      <= 1'b0;
        end else begin
            if (job_accept) begin
                job_regs_q <= job_regs_i;
                retry_q    <= '0;
                error_q    <= 1'b0;
            end
            if (acq_ok) begin
                job_id_q <= txn_rdata[7:0];
                idx_q    <= '0;
            end
            if (acq_fail) begin
                retry_q <= retry_q + RetryW'(1);
                if (retry_last) begin
                    error_q <= 1'b1;
                end
            end
            if (state_q == CFG_BACKOFF) begin
                backoff_q <= backoff_q + BoW'(1);
            end else begin
                backoff_q <= '0;
            end
            if (prog_step) begin
                idx_q <= idx_q + IdxW'(1);
            end
            if (evt_capture) begin
                evt_q <= 1'b1;
            end else if (state_q == CFG_WAIT_EVT) begin
                evt_q <= 1'b0;
            end
        end
    end

    assign job_ready_o = (state_q == CFG_IDLE);
    assign busy_o      = (state_q != CFG_IDLE);
    assign done_o      = (state_q == CFG_DONE);
    assign error_o     = error_q;
    assign job_id_o    = job_id_q;

endmodule

// File: tb/tb_redmule_cfg_master.sv
// Scoreboard bench for redmule_cfg_master with a behavioural periph slave.
// Expected bus transactions are queued by the stimulus thread and checked by the monitor.
// Slave applies configurable grant stalls and scripted acquire responses.
module tb_redmule_cfg_master;

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic             job_valid;
    logic             job_ready_o;
    logic [3:0][31:0] job_regs;
    logic             evt_m;
    logic             evt_s;
    logic             busy_o;
    logic             done_o;
    logic             error_o;
    logic [7:0]       job_id_o;

    redmule_cfg_master_if #(.AddrWidth(32), .ID_WIDTH(8)) periph_if ();

    redmule_cfg_master #(
        .N_REGS    (4),
        .ID_WIDTH  (8),
        .AddrWidth (32),
        .BASE_ADDR (32'h0000_0000),
        .MAX_RETRY (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready_o),
        .job_regs_i  (job_regs),
        .periph      (periph_if),
        .evt_i       (evt_m | evt_s),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .job_id_o    (job_id_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    logic [31:0] acq_q[$];
    int          gap_q[$];

    int txn_cnt  = 0;
    int trig_cnt = 0;
    int done_cnt = 0;

    // slave controls
    int          stall_n     = 0;
    logic        evt_on_trig = 1'b0;
    logic        bad_id_once = 1'b0;
    logic        late_rsp    = 1'b0;
    logic [7:0]  late_id     = '0;
    int          cyc         = 0;
    int          rsp_cyc     = -1;
    logic [7:0]  rd_id       = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rd();
        exp_t e;
        e.add = 32'h04; e.wen = 1'b1; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.add = a; e.wen = 1'b0; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_prog(input logic [3:0][31:0] r);
        for (int i = 0; i < 4; i++) push_wr(32'h40 + 32'(4 * i), r[i]);
        push_wr(32'h00, 32'h0);
    endtask

    task automatic issue_job(input logic [3:0][31:0] r);
        @(negedge clk); #1;
        chk("job_ready_before_issue", job_ready_o, 1);
        @(posedge clk); #1;
        job_valid = 1'b1;
        job_regs  = r;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (busy_o && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, busy_o, 0);
    endtask

    task automatic wait_trig(input int t0, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (trig_cnt == t0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, (trig_cnt != t0), 1);
    endtask

    task automatic pulse_evt();
        @(posedge clk); #1;
        evt_m = 1'b1;
        @(posedge clk); #1;
        evt_m = 1'b0;
    endtask

    // Behavioural slave: grant stalls, acquire responses, id fault injection, event on trigger.
    logic s_prev_req = 1'b0;
    logic s_prev_gnt = 1'b0;
    int   wait_cnt   = 0;
    int   rsp_due    = 0;
    logic [31:0] rsp_val = '0;
    always @(negedge clk) begin
        logic is_new;
        cyc++;
        periph_if.gnt     = 1'b0;
        periph_if.r_valid = 1'b0;
        evt_s             = 1'b0;
        if (late_rsp) begin
            periph_if.r_valid = 1'b1;
            periph_if.r_id    = late_id;
            periph_if.r_data  = 32'h0;
            late_rsp          = 1'b0;
        end else if (rsp_due > 0) begin
            rsp_due--;
            if (rsp_due == 0) begin
                periph_if.r_valid = 1'b1;
                if (bad_id_once) begin
                    periph_if.r_id   = rd_id + 8'd1;
                    periph_if.r_data = 32'h0000_0055;
                    bad_id_once      = 1'b0;
                    rsp_due          = 1;
                end else begin
                    periph_if.r_id   = rd_id;
                    periph_if.r_data = rsp_val;
                    rsp_cyc          = cyc;
                end
            end
        end
        is_new = periph_if.req && !(s_prev_req && !s_prev_gnt);
        if (periph_if.req) begin
            if (is_new && periph_if.wen && rsp_cyc >= 0) begin
                gap_q.push_back(cyc - rsp_cyc);
                rsp_cyc = -1;
            end
            if (wait_cnt < stall_n) begin
                wait_cnt++;
            end else begin
                periph_if.gnt = 1'b1;
                wait_cnt      = 0;
                if (periph_if.wen) begin
                    rd_id   = periph_if.id;
                    rsp_val = (acq_q.size() > 0) ? acq_q.pop_front() : 32'hFFFF_FFFF;
                    rsp_due = 2;
                end else if (periph_if.add == 32'h0 && evt_on_trig) begin
                    evt_s       = 1'b1;
                    evt_on_trig = 1'b0;
                end
            end
        end else begin
            wait_cnt = 0;
        end
        s_prev_req = periph_if.req;
        s_prev_gnt = periph_if.gnt;
    end

    // Monitor: request stability during stalls, scoreboard compare on every handshake.
    logic        m_pend = 1'b0;
    logic [31:0] m_add  = '0;
    logic        m_wen  = 1'b1;
    logic [31:0] m_data = '0;
    logic [7:0]  m_id   = '0;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_ni) begin
            if (m_pend && periph_if.req) begin
                chk("hold_add", periph_if.add, m_add);
                chk("hold_wen", periph_if.wen, m_wen);
                chk("hold_data", periph_if.data, m_data);
                chk("hold_id", periph_if.id, m_id);
            end
            if (periph_if.req && periph_if.gnt) begin
                txn_cnt++;
                if (!periph_if.wen && periph_if.add == 32'h0) trig_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn_add", periph_if.add, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_add", periph_if.add, e.add);
                    chk("txn_wen", periph_if.wen, e.wen);
                    chk("txn_be", periph_if.be, 4'hF);
                    if (!e.wen) chk("txn_data", periph_if.data, e.data);
                end
            end
            if (done_o) done_cnt++;
            m_pend = periph_if.req && !periph_if.gnt;
            m_add  = periph_if.add;
            m_wen  = periph_if.wen;
            m_data = periph_if.data;
            m_id   = periph_if.id;
        end
    end

    initial begin
        logic [3:0][31:0] ra, rb, rc, rd;
        int d0, t0, x0, n;
        ra = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        rb = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
        rc = {32'hC0DE_0004, 32'h1234_5678, 32'h8000_0001, 32'hFFFF_0000};
        rd = {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
        rst_ni    = 1'b0;
        clear_i   = 1'b0;
        job_valid = 1'b0;
        job_regs  = '0;
        evt_m     = 1'b0;
        evt_s     = 1'b0;
        periph_if.gnt     = 1'b0;
        periph_if.r_valid = 1'b0;
        periph_if.r_data  = '0;
        periph_if.r_id    = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // reset state
        @(negedge clk); #1;
        chk("rst_job_ready", job_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_job_id", job_id_o, 0);
        chk("rst_req", periph_if.req, 0);
        chk("rst_wen", periph_if.wen, 1);
        chk("rst_be", periph_if.be, 4'hF);
        chk("rst_add", periph_if.add, 0);
        chk("rst_data", periph_if.data, 0);
        chk("rst_id", periph_if.id, 0);

        // basic job, event 20 cycles after trigger, job_valid ignored while busy
        acq_q.push_back(32'h0000_0001);
        push_rd();
        push_prog(ra);
        d0 = done_cnt; t0 = trig_cnt;
        issue_job(ra);
        wait_trig(t0, 200, "t1_trigger_seen");
        chk("t1_busy", busy_o, 1);
        @(posedge clk); #1;
        job_valid = 1'b1;
        job_regs  = rb;
        repeat (3) begin
            @(negedge clk); #1;
            chk("t1_ready_while_busy", job_ready_o, 0);
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
        repeat (15) @(posedge clk);
        chk("t1_no_early_done", done_cnt - d0, 0);
        pulse_evt();
        wait_idle(50, "t1_back_idle");
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_job_id", job_id_o, 8'h01);
        chk("t1_error", error_o, 0);

        // 5-cycle grant stalls; event coincident with the trigger grant
        stall_n = 5;
        evt_on_trig = 1'b1;
        acq_q.push_back(32'h0000_0007);
        push_rd();
        push_prog(rc);
        d0 = done_cnt; x0 = txn_cnt;
        issue_job(rc);
        wait_idle(400, "t2_back_idle");
        chk("t2_txn_count", txn_cnt - x0, 6);
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_job_id", job_id_o, 8'h07);
        chk("t2_evt_consumed", evt_on_trig, 0);
        stall_n = 0;

        // two refusals then success: 8 idle cycles between attempts
        gap_q.delete();
        rsp_cyc = -1;
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'h0000_0000);
        push_rd(); push_rd(); push_rd();
        push_prog(rd);
        d0 = done_cnt; t0 = trig_cnt;
        issue_job(rd);
        wait_trig(t0, 300, "t3_trigger_seen");
        pulse_evt();
        wait_idle(50, "t3_back_idle");
        chk("t3_gap_count", gap_q.size(), 2);
        n = (gap_q.size() > 0) ? gap_q[0] : -1;
        chk("t3_gap0", n, 9);
        n = (gap_q.size() > 1) ? gap_q[1] : -1;
        chk("t3_gap1", n, 9);
        chk("t3_job_id", job_id_o, 8'h00);
        chk("t3_done_pulses", done_cnt - d0, 1);

        // retries exhausted
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        push_rd(); push_rd(); push_rd();
        d0 = done_cnt;
        issue_job(ra);
        wait_idle(300, "t4_back_idle");
        chk("t4_error", error_o, 1);
        chk("t4_done_pulses", done_cnt - d0, 0);
        chk("t4_job_ready", job_ready_o, 1);
        chk("t4_exp_left", exp_q.size(), 0);

        // mismatched response id ignored; next job also clears error
        bad_id_once = 1'b1;
        acq_q.push_back(32'h0000_0002);
        push_rd();
        push_prog(rb);
        d0 = done_cnt; t0 = trig_cnt;
        issue_job(rb);
        @(negedge clk); #1;
        chk("t5_error_cleared", error_o, 0);
        wait_trig(t0, 200, "t5_trigger_seen");
        pulse_evt();
        wait_idle(50, "t5_back_idle");
        chk("t5_job_id", job_id_o, 8'h02);
        chk("t5_done_pulses", done_cnt - d0, 1);

        // clear during programming, then a stale response
        stall_n = 3;
        acq_q.push_back(32'h0000_0001);
        push_rd();
        push_prog(ra);
        d0 = done_cnt;
        issue_job(ra);
        n = 0;
        @(negedge clk); #1;
        while (!(periph_if.req && periph_if.add == 32'h44) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t6_reached_prog", periph_if.req && periph_if.add == 32'h44, 1);
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(negedge clk); #1;
        chk("t6_req_dropped", periph_if.req, 0);
        @(posedge clk); #1;
        clear_i = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        chk("t6_idle_busy", busy_o, 0);
        chk("t6_idle_ready", job_ready_o, 1);
        chk("t6_job_id", job_id_o, 0);
        x0 = txn_cnt;
        late_id  = rd_id;
        late_rsp = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_stale_busy", busy_o, 0);
        chk("t6_stale_req", periph_if.req, 0);
        chk("t6_stale_txn", txn_cnt - x0, 0);
        chk("t6_done_pulses", done_cnt - d0, 0);
        stall_n = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/redmule_cfg_master.md
Name: redmule_cfg_master

Overview:
- Initiator side of the accelerator peripheral configuration port.
- Accepts a job descriptor (N_REGS 32-bit job registers) from a local sequencer, acquires a job context, and writes every job register through the hwpe_ctrl periph master protocol.
- Fires the trigger, then waits for the accelerator's end-of-job event.
- Sits between a test or host sequencer and the accelerator's control slave; used in the integration bench and in standalone offload wrappers.

Parameters:
- N_REGS, REDMULE_REGS: number of job registers written per job.
- ID_WIDTH, 8: transaction id width.
- AddrWidth, 32: periph address width.
- BASE_ADDR, 32'h0000_0000: accelerator base address.
- MAX_RETRY, 16: number of acquire attempts before the error exit.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear, same effect as reset
- job_valid_i  in  1  job descriptor valid
- job_ready_o  out  1  job accepted (IDLE only)
- job_regs_i  in  N_REGS x 32  job register values, sampled on accept
- periph_req_o  out  1  transaction request
- periph_gnt_i  in  1  grant
- periph_add_o  out  AddrWidth  byte address
- periph_wen_o  out  1  0 = write, 1 = read
- periph_be_o  out  4  byte enables, always 4'hF
- periph_data_o  out  32  write data
- periph_id_o  out  ID_WIDTH  transaction id
- periph_r_valid_i  in  1  response valid
- periph_r_data_i  in  32  read data
- periph_r_id_i  in  ID_WIDTH  response id
- evt_i  in  1  end-of-job event pulse from the accelerator
- busy_o  out  1  a job is in flight
- done_o  out  1  one-cycle pulse at job end
- error_o  out  1  sticky flag: acquire retries exhausted
- job_id_o  out  8  context id returned by acquire

Behaviour:
- Reset/clear: state IDLE; all outputs 0 except periph_be_o = 4'hF and periph_wen_o = 1; error_o and job_id_o cleared.
- Address map (package constants, offsets from BASE_ADDR): TRIGGER 0x00, ACQUIRE 0x04, STATUS 0x0C, SOFT_CLEAR 0x14, REG_BASE 0x40. Job register i is written at BASE_ADDR + REG_BASE + 4*i.
- Protocol:
  - At most one outstanding transaction.
  - req, add, wen, data and id are held stable from req rise until the cycle with req & gnt.
  - A write completes on that grant cycle.
  - A read completes on the first r_valid with r_id == issued id. Responses with a mismatched id are ignored.
  - The id counter increments per transaction (wraps).
- FSM states and transitions:
  - IDLE: job_ready_o = 1. On job_valid_i, latch job_regs_i, clear the retry counter, then go to ACQ_REQ.
  - ACQ_REQ: read from ACQUIRE. On grant, go to ACQ_RESP.
  - ACQ_RESP: on matching r_valid:
    - r_data[31] == 0: latch job_id_o = r_data[7:0], reset the register index to 0, go to PROG.
    - r_data[31] == 1 (no free context): increment the retry counter. If the counter reaches MAX_RETRY, set error_o and go to IDLE without asserting done_o. Otherwise go to BACKOFF.
  - BACKOFF: wait 8 cycles, then go to ACQ_REQ.
  - PROG: write job_regs[idx]. On grant, idx++. After the write with idx == N_REGS-1 is granted, go to TRIG.
  - TRIG: write 0 to TRIGGER. On grant, go to WAIT_EVT.
  - WAIT_EVT: on evt_i, go to DONE.
  - DONE: done_o = 1 for exactly one cycle, then IDLE.
- busy_o = 1 in every state except IDLE.
- evt_i is only honoured in WAIT_EVT. If evt_i arrives on the same cycle as the TRIG grant, it is captured and WAIT_EVT exits on the next cycle.
- A new job_valid_i while busy is not accepted; job_ready_o stays 0.
- clear_i mid-transaction drops req immediately. A later stale response is ignored by the id check.
- error_o clears on the next accepted job.

Decomposition:
- redmule_pkg gains:
  - the periph offset constants (REDMULE_TRIGGER, REDMULE_ACQUIRE, REDMULE_STATUS, REDMULE_SOFT_CLEAR, REDMULE_REG_BASE);
  - the cfg-master state enum;
  - the BACKOFF length constant.
- Sub-module redmule_periph_txn: single-outstanding request/response engine. It holds the request stable, manages the id counter, performs id matching, and reports txn_done_o.

Test Plan:
- N_REGS = 4, acquire returns 0x0000_0001: exactly 4 writes at 0x40/0x44/0x48/0x4C with the latched data, then a write to 0x00. Pulse evt_i 20 cycles later: done_o high for exactly 1 cycle, job_id_o = 1.
- Grant stalled 5 cycles per request: address, data and wen are stable throughout each stall. Total transactions = 1 read + 5 writes.
- Acquire returns 0xFFFF_FFFF twice, then 0x0000_0000: 3 acquire reads separated by 8 idle cycles, then programming starts.
- Acquire always returns 0xFFFF_FFFF with MAX_RETRY = 3: error_o = 1 after the 3rd response, back in IDLE, done_o never asserted.
- Response carrying a wrong r_id followed by the correct one: the first is ignored and the FSM advances only on the matching id.
- clear_i asserted during PROG: req drops that cycle, IDLE next cycle, and a late r_valid causes no state change.
